// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - single-port memory arbiter between IF and LS
// One access in flight; round-robin grant on req/gnt, fixed-latency rvalid routed back to the owner.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic                clock_i,
  input  logic                reset_i,
  input  logic                if_req_i,
  input  logic [ADDR_W-1:0]   if_addr_i,
  output logic                if_gnt_o,
  output logic                if_rvalid_o,
  output logic [DATA_W-1:0]   if_rdata_o,
  input  logic                ls_req_i,
  input  logic                ls_we_i,
  input  logic [ADDR_W-1:0]   ls_addr_i,
  input  logic [DATA_W-1:0]   ls_wdata_i,
  input  logic [DATA_W/8-1:0] ls_be_i,
  output logic                ls_gnt_o,
  output logic                ls_rvalid_o,
  output logic [DATA_W-1:0]   ls_rdata_o,
  output logic                mem_en_o,
  output logic                mem_we_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  output logic [DATA_W/8-1:0] mem_be_o,
  input  logic [DATA_W-1:0]   mem_rdata_i,
  output logic [15:0]         stall_count_o
);
  localparam logic [3:0] LAT = 4'(MEM_LAT);

  typedef enum logic {IDLE, BUSY} state_e;
  typedef enum logic {PORT_IF, PORT_LS} port_e;

  state_e      state_q, state_d;
  port_e       owner_q, owner_d;
  port_e       rr_q, rr_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] stall_q, stall_d;

  logic window, resp, pick_ls, if_gnt, ls_gnt, stalled;

  // The response cycle reopens the window so a waiting port can issue back-to-back.
  assign window  = (state_q == IDLE) || (cnt_q == 4'd1);
  assign resp    = (state_q == BUSY) && (cnt_q == 4'd1) && !reset_i;
  assign pick_ls = ls_req_i && (!if_req_i || rr_q == PORT_IF);
  assign if_gnt  = window && !reset_i && if_req_i && !pick_ls;
  assign ls_gnt  = window && !reset_i && pick_ls;
  assign stalled = (if_req_i && !if_gnt) || (ls_req_i && !ls_gnt);

  assign if_gnt_o      = if_gnt;
  assign ls_gnt_o      = ls_gnt;
  assign if_rvalid_o   = resp && (owner_q == PORT_IF);
  assign ls_rvalid_o   = resp && (owner_q == PORT_LS);
  assign if_rdata_o    = mem_rdata_i;
  assign ls_rdata_o    = mem_rdata_i;
  assign stall_count_o = stall_q;

  always_comb begin
    mem_en_o    = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_be_o    = '0;
    if (if_gnt) begin
      mem_en_o   = 1'b1;
      mem_addr_o = if_addr_i;
      mem_be_o   = '1;
    end else if (ls_gnt) begin
      mem_en_o    = 1'b1;
      mem_we_o    = ls_we_i;
      mem_addr_o  = ls_addr_i;
      mem_wdata_o = ls_wdata_i;
      mem_be_o    = ls_be_i;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    stall_d = stall_q;
    if (if_gnt || ls_gnt) begin
      state_d = BUSY;
      cnt_d   = LAT;
      owner_d = ls_gnt ? PORT_LS : PORT_IF;
      rr_d    = ls_gnt ? PORT_LS : PORT_IF;
    end else if (state_q == BUSY) begin
      cnt_d = cnt_q - 4'd1;
      if (cnt_q == 4'd1) begin
        state_d = IDLE;
      end
    end
    if (stalled && stall_q != 16'hFFFF) begin
      stall_d = stall_q + 16'd1;
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      owner_q <= PORT_IF;
      rr_q    <= PORT_LS;
      cnt_q   <= 4'd0;
      stall_q <= 16'd0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
      stall_q <= stall_d;
    end
  end
endmodule
